// File: rtl/disp_arb_pkg.sv
// disp_arb_pkg: shared types and constants for the display arbiter.
// Holds the FSM state encoding, the hold-counter width helper and the
// nibble positions that map a 16-bit value onto dig1..dig4.
package disp_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } disp_state_e;

  localparam int VAL_W = 16;
  localparam int NIB_W = 4;

  // Nibble index inside a 16-bit value; dig1 is the leftmost digit.
  localparam int DIG1_NIB = 3;
  localparam int DIG2_NIB = 2;
  localparam int DIG3_NIB = 1;
  localparam int DIG4_NIB = 0;

  // Width needed for a counter that must hold the value hold_ticks.
  function automatic int cnt_w(input int hold_ticks);
    return $clog2(hold_ticks + 1);
  endfunction

endpackage

// File: rtl/disp_arbiter_rr_pick.sv
// rr_pick: combinational one-hot winner selector.
// Default: round-robin, search starts one past last_owner and wraps.
// With DISP_ARB_PRIORITY_EN defined: fixed priority, lowest index wins.
module rr_pick #(
  parameter int NREQ  = 3,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_owner,
  output logic [NREQ-1:0]  winner,
  output logic             valid
);

`ifdef DISP_ARB_PRIORITY_EN
  logic unused_last_owner;
  assign unused_last_owner = ^last_owner;

  // Lowest set request bit wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!valid && req[i]) begin
        winner[i] = 1'b1;
        valid     = 1'b1;
      end
    end
  end
`else
  // Step k visits index (last_owner + k) mod NREQ; the first set bit wins.
  // Both loops are constant so each step compares last_owner to a constant
  // rather than computing a variable index.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!valid && req[i] &&
            (last_owner == IDX_W'((i - k + NREQ) % NREQ))) begin
          winner[i] = 1'b1;
          valid     = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/disp_arbiter.sv
// disp_arbiter: shares the 4-digit seven-segment display between NREQ
// requesters. One owner at a time, a minimum hold measured in ticks, and a
// one-clk gap with no grant at every handover.
// Optional build macro: DISP_ARB_PRIORITY_EN (fixed priority with immediate
// preemption by a lower-index requester).
module disp_arbiter
  import disp_arb_pkg::*;
#(
  parameter int          NREQ       = 3,
  parameter int          HOLD_TICKS = 250,
  parameter logic [15:0] IDLE_VALUE = 16'h0000
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 tick,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   value,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic [3:0]           dig1,
  output logic [3:0]           dig2,
  output logic [3:0]           dig3,
  output logic [3:0]           dig4
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = cnt_w(HOLD_TICKS);

  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NREQ - 1);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] OWN  = ST_OWN;
  localparam logic [1:0] GAP  = ST_GAP;

  logic [1:0]       state;
  logic [NREQ-1:0]  grant_r;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] last_owner;
  logic [VAL_W-1:0] disp_val;

  logic [NREQ-1:0]  pick_oh;
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic [VAL_W-1:0] pick_val;
  logic [VAL_W-1:0] own_val;
  logic             own_req;
  logic             other_req;
  logic             pre_hi;
  logic             release_own;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (req),
    .last_owner (last_owner),
    .winner     (pick_oh),
    .valid      (pick_vld)
  );

  // Decode the winner and current owner into indices/values and form the
  // release condition. Owner is identified by the registered one-hot grant.
  always_comb begin
    pick_idx = '0;
    pick_val = '0;
    own_val  = '0;
    pre_hi   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) begin
        pick_idx = IDX_W'(i);
        pick_val = value[VAL_W*i +: VAL_W];
      end
      own_val = own_val | ({VAL_W{grant_r[i]}} & value[VAL_W*i +: VAL_W]);
    end
`ifdef DISP_ARB_PRIORITY_EN
    // Any pending request below the owner's index takes over at once.
    for (int i = 0; i < NREQ; i++) begin
      for (int j = i + 1; j < NREQ; j++) begin
        if (grant_r[j] && req[i]) pre_hi = 1'b1;
      end
    end
`endif
    own_req     = |(req & grant_r);
    other_req   = |(req & ~grant_r);
    release_own = !own_req || ((cnt == '0) && other_req) || pre_hi;
  end

  // Arbiter FSM, hold counter, last owner and displayed value.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= IDLE;
      grant_r    <= '0;
      cnt        <= '0;
      last_owner <= LAST_RST;
      disp_val   <= IDLE_VALUE;
    end else begin
      case (state)
        OWN: begin
          disp_val <= own_val;
          if (release_own) begin
            state   <= GAP;
            grant_r <= '0;
          end else if (tick && (cnt != '0)) begin
            cnt <= cnt - CNT_ONE;
          end
        end
        IDLE, GAP: begin
          if (pick_vld) begin
            state      <= OWN;
            grant_r    <= pick_oh;
            cnt        <= HOLD_INIT;
            last_owner <= pick_idx;
            disp_val   <= pick_val;
          end else begin
            state    <= IDLE;
            disp_val <= IDLE_VALUE;
          end
        end
        default: begin
          state   <= IDLE;
          grant_r <= '0;
          disp_val <= IDLE_VALUE;
        end
      endcase
    end
  end

  assign grant = grant_r;
  assign busy  = (state == OWN);
  assign dig1  = disp_val[DIG1_NIB*NIB_W +: NIB_W];
  assign dig2  = disp_val[DIG2_NIB*NIB_W +: NIB_W];
  assign dig3  = disp_val[DIG3_NIB*NIB_W +: NIB_W];
  assign dig4  = disp_val[DIG4_NIB*NIB_W +: NIB_W];

endmodule

// File: tb/tb_disp_arbiter.sv
// tb_disp_arbiter: directed scenarios plus random traffic, checked against
// an ownership model (who owns, ticks left, last owner, shown value).
module tb_disp_arbiter;

  localparam int          N    = 3;
  localparam int          HOLD = 4;
  localparam logic [15:0] IDLE = 16'hA5A5;

  logic          clk;
  logic          clr;
  logic          tick;
  logic [N-1:0]  req;
  logic [16*N-1:0] value;
  logic [N-1:0]  grant;
  logic          busy;
  logic [3:0]    dig1, dig2, dig3, dig4;

  int errs   = 0;
  int checks = 0;

  // Reference model state.
  int          m_owner;
  int          m_hold;
  int          m_last;
  logic [15:0] m_dig;

  disp_arbiter #(
    .NREQ       (N),
    .HOLD_TICKS (HOLD),
    .IDLE_VALUE (IDLE)
  ) dut (
    .clk   (clk),
    .clr   (clr),
    .tick  (tick),
    .req   (req),
    .value (value),
    .grant (grant),
    .busy  (busy),
    .dig1  (dig1),
    .dig2  (dig2),
    .dig3  (dig3),
    .dig4  (dig4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int last);
`ifdef DISP_ARB_PRIORITY_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (r[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_hold  = 0;
    m_last  = N - 1;
    m_dig   = IDLE;
  endtask

  // Advance the model by one clock edge using the inputs now applied.
  task automatic model_step();
    bit rel;
    int w;
    if (m_owner >= 0) begin
      rel = !req[m_owner] || (m_hold == 0 && (req & ~(N'(1) << m_owner)) != 0);
`ifdef DISP_ARB_PRIORITY_EN
      for (int i = 0; i < m_owner; i++) if (req[i]) rel = 1'b1;
`endif
      m_dig = value[16*m_owner +: 16];
      if (rel) m_owner = -1;
      else if (tick && m_hold > 0) m_hold--;
    end else begin
      w = pick(req, m_last);
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_hold  = HOLD;
        m_dig   = value[16*w +: 16];
      end else begin
        m_dig = IDLE;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [N-1:0] eg;
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    chk({tag, "_grant"}, 32'(grant), 32'(eg));
    chk({tag, "_busy"}, 32'(busy), 32'(m_owner >= 0));
    chk({tag, "_dig"}, 32'({dig1, dig2, dig3, dig4}), 32'(m_dig));
    chk({tag, "_onehot"}, 32'($onehot0(grant)), 32'd1);
  endtask

  // Called at a negedge: apply inputs, step the model, compare next negedge.
  task automatic cycle(input string tag, input logic [N-1:0] r,
                       input logic [16*N-1:0] v, input logic t);
    req   = r;
    value = v;
    tick  = t;
    model_step();
    @(negedge clk);
    compare_all(tag);
  endtask

  // Called at a negedge: async reset, check outputs, release next negedge.
  task automatic do_reset();
    clr = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dig", 32'({dig1, dig2, dig3, dig4}), 32'(IDLE));
    model_reset();
    @(negedge clk);
    clr = 1'b1;
  endtask

  logic [16*N-1:0] vals;
  logic [N-1:0]    rr;

  initial begin
    clr   = 1'b0;
    tick  = 1'b0;
    req   = 3'b111;
    vals  = {16'h3333, 16'h2222, 16'h1111};
    value = vals;
    model_reset();
    @(negedge clk);
    @(negedge clk);

    // Reset with all requesting, then first grant goes to index 0.
    do_reset();
    cycle("first", 3'b111, vals, 1'b0);
    chk("first_lit", 32'(grant), 32'd1);
    chk("first_val", 32'({dig1, dig2, dig3, dig4}), 32'h1111);

    // Hold time: req[1] waits for four ticks, then a gap, then owner 1.
    do_reset();
    cycle("hold0", 3'b001, vals, 1'b0);
    cycle("hold1", 3'b011, vals, 1'b1);
    cycle("hold2", 3'b011, vals, 1'b0);
    cycle("hold3", 3'b011, vals, 1'b1);
    cycle("hold4", 3'b011, vals, 1'b1);
    cycle("hold5", 3'b011, vals, 1'b1);
    chk("hold_still0", 32'(grant), 32'd1);
    cycle("hold6", 3'b011, vals, 1'b0);
    chk("hold_gap", 32'(grant), 32'd0);
    cycle("hold7", 3'b011, vals, 1'b0);
    chk("hold_new", 32'(grant), 32'd2);

    // Live value tracking for owner 1.
    do_reset();
    cycle("trk0", 3'b010, {16'h3333, 16'h1234, 16'h1111}, 1'b0);
    cycle("trk1", 3'b010, {16'h3333, 16'hBEEF, 16'h1111}, 1'b0);
    chk("trk_beef", 32'({dig1, dig2, dig3, dig4}), 32'hBEEF);

    // All requesting continuously with ticks: full rotation.
    do_reset();
    for (int i = 0; i < 24; i++) cycle("rot", 3'b111, vals, 1'b1);

    // Owner drops early: gap then idle value.
    do_reset();
    cycle("drop0", 3'b001, vals, 1'b1);
    cycle("drop1", 3'b000, vals, 1'b0);
    cycle("drop2", 3'b000, vals, 1'b0);
    chk("drop_idle", 32'({dig1, dig2, dig3, dig4}), 32'(IDLE));

    // Reset while owning: grant falls without waiting for a clock.
    cycle("mid0", 3'b100, vals, 1'b0);
    #2;
    do_reset();
    cycle("mid1", 3'b100, vals, 1'b0);

    // Random traffic with sticky requests.
    rr = 3'b000;
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) rr[b] = ~rr[b];
      for (int b = 0; b < N; b++)
        if ($urandom_range(3) == 0) vals[16*b +: 16] = 16'($urandom);
      cycle("rnd", rr, vals, ($urandom_range(2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
